// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_sched
//  Purpose  : N-channel registered mux, fixed-select or round-robin grant,
//             valid/ready on every input and on the single output.
//  Revision : 1.0  initial release
// ============================================================================
module mux_rr_sched #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   C_N    = (SEL_W + 1)'(N);

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [SEL_W-1:0] r_chan;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_fix_hit;
    logic             w_rr_hit;
    logic [SEL_W-1:0] w_rr_grant;
    logic [SEL_W:0]   w_scan;
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_next_ptr;
    logic [W-1:0]     w_grant_data;

    // Register may accept a new word when empty or being drained this cycle.
    assign w_load_en = !r_valid || out_ready;

    // Fixed select: compare against each legal index so sel >= N never matches.
    always_comb begin
        w_fix_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_fix_hit = 1'b1;
            end
        end
    end

    // Round robin: first valid channel scanning upward from r_rr_ptr, wrapping.
    always_comb begin
        w_rr_hit   = 1'b0;
        w_rr_grant = '0;
        w_scan     = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
            if (w_scan >= C_N) begin
                w_scan = w_scan - C_N;
            end
            if (!w_rr_hit && in_valid[w_scan[SEL_W-1:0]]) begin
                w_rr_hit   = 1'b1;
                w_rr_grant = w_scan[SEL_W-1:0];
            end
        end
    end

    assign w_grant     = mode ? w_rr_grant : sel;
    assign w_grant_vld = mode ? w_rr_hit   : w_fix_hit;
    assign w_next_ptr  = (w_grant == C_LAST) ? '0 : w_grant + SEL_W'(1);

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && w_load_en && w_grant_vld && (w_grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_chan   <= '0;
            r_rr_ptr <= '0;
        end else if (w_load_en) begin
            if (w_grant_vld) begin
                r_valid <= 1'b1;
                r_data  <= w_grant_data;
                r_chan  <= w_grant;
                if (mode) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_chan  = r_chan;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_sched
//  Purpose  : Self-checking bench for mux_rr_sched (N=4 W=1, plus an N=3 copy).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] in_data = 4'b0000;
    logic [3:0] in_valid = 4'b0000;
    logic [3:0] in_ready;
    logic [0:0] out_data;
    logic [1:0] out_chan;
    logic       out_valid;
    logic       out_ready = 1'b0;

    logic [1:0] sel3 = 2'd3;
    logic [2:0] in_data3 = 3'b111;
    logic [2:0] in_valid3 = 3'b111;
    logic [2:0] in_ready3;
    logic [0:0] out_data3;
    logic [1:0] out_chan3;
    logic       out_valid3;

    int n_checks = 0;
    int n_errors = 0;

    logic       m_on = 1'b0;
    logic       m_valid = 1'b0;
    int         m_rr = 0;
    logic [2:0] sb[$];

    mux_rr_sched #(.N(4), .W(1)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_rr_sched #(.N(3), .W(1)) dut3 (
        .clk(clk), .rst(rst), .mode(1'b0), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(1'b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void model_grant(output logic hit, output int g);
        hit = 1'b0;
        g   = 0;
        if (!mode) begin
            if (in_valid[sel]) begin
                hit = 1'b1;
                g   = int'(sel);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_rr + k) % 4;
                if (!hit && in_valid[j]) begin
                    hit = 1'b1;
                    g   = j;
                end
            end
        end
    endfunction

    // One clock: mid-cycle compare against the model, then advance the model.
    task automatic cycle();
        logic       hit;
        int         g;
        logic       load;
        logic [3:0] er;
        @(negedge clk);
        model_grant(hit, g);
        load = !m_valid || out_ready;
        er   = (!rst && load && hit) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(er));
        if (m_on) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    chk("out_word", 32'({out_chan, out_data}), 32'(sb[0]));
                end
            end
        end
        if (rst) begin
            m_on    = 1'b1;
            m_valid = 1'b0;
            m_rr    = 0;
            sb.delete();
        end else if (load) begin
            if (m_valid && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            if (hit) begin
                sb.push_back({2'(g), in_data[g]});
                m_valid = 1'b1;
                if (mode) begin
                    m_rr = (g + 1) % 4;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int         t3_chan [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
    logic [3:0] t2_data = 4'b1101;

    initial begin
        // T1: reset held two cycles with every channel requesting
        in_valid = 4'hF;
        in_data  = 4'b1101;
        cycle();
        cycle();
        chk("t1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_out_data", 32'(out_data), 32'd0);
        chk("t1_out_chan", 32'(out_chan), 32'd0);
        chk("t1_out_valid3", 32'(out_valid3), 32'd0);
        rst = 1'b0;

        // T2: fixed select truth table
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cycle();
            chk("t2_chan", 32'(out_chan), 32'(s));
            chk("t2_data", 32'(out_data), 32'(t2_data[s]));
        end

        // T3: round robin, full set then alternating pair
        mode = 1'b1;
        for (int n = 0; n < 12; n++) begin
            in_valid = (n < 8) ? 4'hF : 4'b1010;
            cycle();
            chk("t3_chan", 32'(out_chan), 32'(t3_chan[n]));
            chk("t3_valid", 32'(out_valid), 32'd1);
        end

        // T4: backpressure on a word from channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'hF;
        cycle();
        out_ready = 1'b0;
        sel       = 2'd1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("t4_hold_chan", 32'(out_chan), 32'd2);
            chk("t4_hold_data", 32'(out_data), 32'd1);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("t4_next_chan", 32'(out_chan), 32'd1);
        chk("t4_next_data", 32'(out_data), 32'd0);

        // T5: fixed select on an idle channel; N=3 copy with sel=3
        sel      = 2'd2;
        in_valid = 4'b1011;
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        cycle();
        chk("t5_drained", 32'(out_valid), 32'd0);
        cycle();
        chk("t5_idle", 32'(out_valid), 32'd0);
        chk("t5_n3_ready", 32'(in_ready3), 32'd0);
        chk("t5_n3_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd2;
        #1;
        chk("t5_n3_ready2", 32'(in_ready3), 32'b100);
        cycle();
        chk("t5_n3_chan", 32'(out_chan3), 32'd2);

        // T6: reset while a word is held, round robin restarts at 0
        mode     = 1'b1;
        in_valid = 4'hF;
        cycle();
        chk("t6_first", 32'(out_chan), 32'd0);
        out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("t6_restart", 32'(out_chan), 32'd0);
        cycle();
        chk("t6_second", 32'(out_chan), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
